// File: rtl/walk_sensor_frontend_if.sv
// rtl/walk_sensor_frontend_if.sv - bundle of walk/sensor front-end inputs and controller-facing outputs
interface walk_sensor_frontend_if;
  logic       tick;
  logic [3:0] wlk_raw;
  logic       sensor_raw;
  logic       walk_ack;
  logic       jam_clr;
  logic [3:0] walk_src;
  logic       walk_req;
  logic       sensor_db;
  logic       jam;

  modport master (
    output tick, wlk_raw, sensor_raw, walk_ack, jam_clr,
    input  walk_src, walk_req, sensor_db, jam
  );

  modport slave (
    input  tick, wlk_raw, sensor_raw, walk_ack, jam_clr,
    output walk_src, walk_req, sensor_db, jam
  );
endinterface

// File: rtl/walk_sensor_frontend.sv
// rtl/walk_sensor_frontend.sv - synchronizes and debounces walk buttons and side-road sensor, latches walk requests and jam flag
module walk_sensor_frontend #(
  parameter int unsigned DB_TICKS  = 4,
  parameter int unsigned JAM_TICKS = 6
) (
  input logic                  clk,
  input logic                  rst,
  walk_sensor_frontend_if.slave bus
);

  localparam logic [7:0] DB_LIM  = 8'(DB_TICKS);
  localparam logic [7:0] JAM_LIM = 8'(JAM_TICKS);

  logic [4:0] raw;
  logic [4:0] sync1;
  logic [4:0] sync2;
  logic [4:0] db;
  logic [7:0] cnt [5];
  logic [3:0] db_prev;
  logic [3:0] rise;
  logic [3:0] walk_src;
  logic       walk_req;
  logic [7:0] jcnt;
  logic       jam;

  // bit 4 is the vehicle sensor, bits 3:0 the crossing buttons
  assign raw = {bus.sensor_raw, bus.wlk_raw};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db <= '0;
      for (int i = 0; i < 5; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (bus.tick) begin
          if (cnt[i] + 8'd1 == DB_LIM) begin
            db[i]  <= ~db[i];
            cnt[i] <= '0;
          end else begin
            cnt[i] <= cnt[i] + 8'd1;
          end
        end
      end
    end
  end

  assign rise = db[3:0] & ~db_prev;

  // a press rising in the same clk as walk_ack survives the clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_prev  <= '0;
      walk_src <= '0;
      walk_req <= 1'b0;
    end else begin
      db_prev  <= db[3:0];
      walk_src <= (bus.walk_ack ? 4'b0000 : walk_src) | rise;
      walk_req <= |walk_src;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      jcnt <= '0;
      jam  <= 1'b0;
    end else if (bus.jam_clr) begin
      jcnt <= '0;
      jam  <= 1'b0;
    end else if (!db[4]) begin
      jcnt <= '0;
    end else if (bus.tick && jcnt < JAM_LIM) begin
      jcnt <= jcnt + 8'd1;
      if (jcnt + 8'd1 == JAM_LIM) jam <= 1'b1;
    end
  end

  assign bus.walk_src  = walk_src;
  assign bus.walk_req  = walk_req;
  assign bus.sensor_db = db[4];
  assign bus.jam       = jam;

endmodule

// File: doc/walk_sensor_frontend.md
WALK_SENSOR_FRONTEND -- requirements
Module: walk_sensor_frontend

Interface
REQ-001 The block SHALL expose parameter DB_TICKS, default 4, debounce qualification length in tick periods (legal 1..255).
REQ-002 The block SHALL expose parameter JAM_TICKS, default 6, sensor-held duration in tick periods that declares a jam (legal 1..255).
REQ-003 clk  input  1  single system clock, all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 tick  input  1  one-clk-wide timebase enable from the clock divider; all debounce/jam counting advances only when tick=1.
REQ-006 wlk_raw  input  4  raw pedestrian buttons, asynchronous to clk, bit i = crossing i+1.
REQ-007 sensor_raw  input  1  raw side-road vehicle sensor, asynchronous to clk.
REQ-008 walk_ack  input  1  one-clk pulse from the light controller when a pedestrian all-red phase begins.
REQ-009 jam_clr  input  1  one-clk pulse from the light controller when a jam-shortened phase is served.
REQ-010 walk_src  output  4  sticky per-crossing pending requests.
REQ-011 walk_req  output  1  OR of walk_src, registered; feeds controller walk input.
REQ-012 sensor_db  output  1  debounced sensor level.
REQ-013 jam  output  1  sticky congestion flag for the controller.

Function
REQ-014 Each of the five raw inputs SHALL pass through its own two-flop synchronizer before any other logic.
REQ-015 Each synchronized input SHALL have an independent debouncer: debounced level db, counter cnt (8 bits).
REQ-016 Debouncer: sync == db -> cnt cleared to 0 every clk; sync != db and tick=1 -> cnt increments; when cnt reaches DB_TICKS, db toggles and cnt clears in the same clk.
REQ-017 A glitch shorter than DB_TICKS ticks SHALL never change db; a single matching sample restarts qualification from 0.
REQ-018 A rising edge of debounced button i (db now 1, previous clk 0) SHALL set walk_src[i] on the following clk edge; falling edges have no effect.
REQ-019 walk_ack=1 SHALL clear all walk_src bits, except a bit whose rising edge occurs in the same clk, which SHALL end set (new press wins).
REQ-020 walk_req SHALL equal the OR of walk_src delayed one clk; worst-case latency raw press to walk_req = 2 (sync) + DB_TICKS tick periods + 2 clk.
REQ-021 Holding a button SHALL register one request only; re-request requires release and re-press, each debounced.
REQ-022 Jam counter jcnt (8 bits): sensor_db=0 -> jcnt=0; sensor_db=1 and tick=1 -> jcnt increments, saturating at JAM_TICKS.
REQ-023 jam SHALL set on the clk edge where jcnt reaches JAM_TICKS and remain 1 until jam_clr.
REQ-024 jam_clr=1 SHALL clear jam and jcnt; jam_clr wins over a simultaneous set; if sensor_db is still 1, counting restarts from 0 on the next tick, so jam re-asserts no sooner than JAM_TICKS ticks later.
REQ-025 jam_clr while jam=0 SHALL only clear jcnt.
REQ-026 tick=0 for any number of clk SHALL freeze all counters; synchronizers, edge detection, ack/clr handling continue every clk.

Reset
REQ-027 rst=0 SHALL immediately, without clk, force synchronizer flops, all db, cnt, jcnt, walk_src, walk_req, sensor_db, jam to 0.
REQ-028 An input held high through reset release SHALL be treated as a new rising level and debounced normally (one request results after DB_TICKS ticks).
REQ-029 Reset asserted mid-qualification SHALL discard partial counts; no request or jam is generated from pre-reset activity.

Verification
REQ-030 DB_TICKS=4, tick every 10 clk: wlk_raw[2] high steady -> walk_src=4'b0100 and walk_req=1 within 2+40+2 clk; no other bit set.
REQ-031 wlk_raw[0] pulses high for 3 ticks, low for 1, high 3 -> walk_src stays 0.
REQ-032 walk_src=4'b0001 pending, walk_ack coincides with debounced rise of button 3 -> walk_src=4'b1000 next clk, walk_req stays 1.
REQ-033 JAM_TICKS=6: sensor_raw high -> jam=1 exactly 6 ticks after sensor_db rises; jam_clr with sensor held -> jam=0, re-asserts 6 ticks later; sensor drops at tick 5 -> jam never sets.
REQ-034 Drive jam=1 and walk_src=4'b1111, assert rst=0 mid-clk -> all outputs 0 before next clk edge; release with inputs low -> outputs stay 0.
